// File: rtl/inv_mix_columns_seq.sv
// Iterative dual-rail (WDDL-style) AES InvMixColumns engine.
// Each 32-bit column is evaluated in its own cycle, and a spacer cycle
// precedes every evaluation. The rails therefore see a fixed,
// data-independent switching profile.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   InvMix_In_T/F, In_Valid       input state rails plus handshake
//   In_Ready                      high only in IDLE
//   InvMix_Out_T/F, Out_Valid     result rails (spacer unless DONE)
//   Out_Ready                     downstream accept
//   Out_Err                       input held a (0,0) or (1,1) rail pair

// One output byte of a column, on both rails. Each element of colIn
// is {T byte, F byte}. colIn[0] is the byte that gets the 0e
// coefficient, followed by 0b, 0d and 09 in rotation order.
module inv_mix_columns_lane (
  input  logic [3:0][15:0] colIn,
  output logic [15:0]      byteOut
);
  // Dual-rail XOR. It maps spacer to spacer and codeword to codeword.
  function automatic logic [15:0] dXor(input logic [15:0] a, input logic [15:0] b);
    return {(a[15:8] & b[7:0]) | (a[7:0] & b[15:8]),
            (a[15:8] & b[15:8]) | (a[7:0] & b[7:0])};
  endfunction

  // Dual-rail xtime. Bit 7 is rotated into bit 0 and then XORed into
  // bits 1, 3 and 4, which gives the 0x1B reduction. Positions left
  // untouched receive a dual-rail constant 0 (T=0, F=1). A spacer
  // input still yields a spacer output.
  function automatic logic [15:0] dXtime(input logic [15:0] a);
    logic [15:0] rot, msk;
    rot = {a[14:8], a[15], a[6:0], a[7]};
    msk = {3'b000, a[15], a[15], 1'b0, a[15], 1'b0,
           3'b111, a[7],  a[7],  1'b1, a[7],  1'b1};
    return dXor(rot, msk);
  endfunction

  logic [3:0][15:0] x1, x2, x3;
  logic [15:0]      t0, t1, t2, t3;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      x1[i] = dXtime(colIn[i]);
      x2[i] = dXtime(x1[i]);
      x3[i] = dXtime(x2[i]);
    end
    t0      = dXor(dXor(x3[0], x2[0]), x1[0]);    // 0e
    t1      = dXor(dXor(x3[1], x1[1]), colIn[1]); // 0b
    t2      = dXor(dXor(x3[2], x2[2]), colIn[2]); // 0d
    t3      = dXor(x3[3], colIn[3]);              // 09
    byteOut = dXor(dXor(t0, t1), dXor(t2, t3));
  end
endmodule

module inv_mix_columns_seq #(
  parameter int N    = 128,
  parameter int Nb   = 4,
  parameter int BYTE = 8,
  parameter int WORD = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] InvMix_In_T,
  input  logic [N-1:0] InvMix_In_F,
  input  logic         In_Valid,
  output logic         In_Ready,
  output logic [N-1:0] InvMix_Out_T,
  output logic [N-1:0] InvMix_Out_F,
  output logic         Out_Valid,
  input  logic         Out_Ready,
  output logic         Out_Err
);
  typedef enum logic [1:0] {IDLE, PRE, EVAL, DONE} state_t;

  state_t          state;
  logic [1:0]      col;
  logic            err;
  logic [N-1:0]    capT, capF, resT, resF;
  logic [WORD-1:0] mixInT, mixInF, mixOutT, mixOutF;

  logic [Nb-1:0][15:0]         colDr;
  logic [Nb-1:0][Nb-1:0][15:0] laneIn;
  logic [Nb-1:0][15:0]         laneOut;

  // Column mux. It drives spacer in every state except EVAL, so each
  // evaluation is preceded by a full precharge of the network.
  always_comb begin
    mixInT = '0;
    mixInF = '0;
    if (state == EVAL)
      for (int c = 0; c < Nb; c++)
        if (col == 2'(c)) begin
          mixInT = capT[N-1-c*WORD -: WORD];
          mixInF = capF[N-1-c*WORD -: WORD];
        end
  end

  genvar r, i;
  generate
    for (r = 0; r < Nb; r++) begin : gLane
      assign colDr[r] = {mixInT[WORD-1-r*BYTE -: BYTE], mixInF[WORD-1-r*BYTE -: BYTE]};
      // Output byte r takes the inputs rotated so that a[r] carries 0e.
      for (i = 0; i < Nb; i++) begin : gRot
        assign laneIn[r][i] = colDr[(r+i)%Nb];
      end
      inv_mix_columns_lane uLane (.colIn(laneIn[r]), .byteOut(laneOut[r]));
      assign mixOutT[WORD-1-r*BYTE -: BYTE] = laneOut[r][15:8];
      assign mixOutF[WORD-1-r*BYTE -: BYTE] = laneOut[r][7:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      col   <= '0;
      err   <= 1'b0;
      capT  <= '0;
      capF  <= '0;
      resT  <= '0;
      resF  <= '0;
    end else begin
      case (state)
        IDLE: if (In_Valid) begin
          capT  <= InvMix_In_T;
          capF  <= InvMix_In_F;
          resT  <= '0;
          resF  <= '0;
          err   <= |(~(InvMix_In_T ^ InvMix_In_F));
          col   <= '0;
          state <= PRE;
        end
        PRE: state <= EVAL;
        EVAL: begin
          // On a rail error the result stays spacer, but the sequence
          // still runs to completion so the timing does not depend on data.
          if (!err)
            for (int c = 0; c < Nb; c++)
              if (col == 2'(c)) begin
                resT[N-1-c*WORD -: WORD] <= mixOutT;
                resF[N-1-c*WORD -: WORD] <= mixOutF;
              end
          if (col == 2'(Nb-1)) state <= DONE;
          else begin
            col   <= col + 2'd1;
            state <= PRE;
          end
        end
        DONE: if (Out_Ready) begin
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign In_Ready     = (state == IDLE);
  assign Out_Valid    = (state == DONE);
  assign Out_Err      = (state == DONE) && err;
  assign InvMix_Out_T = (state == DONE) ? resT : '0;
  assign InvMix_Out_F = (state == DONE) ? resF : '0;
endmodule

// File: tb/tb_inv_mix_columns_seq.sv
module tb_inv_mix_columns_seq;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] InvMix_In_T = '0, InvMix_In_F = '0;
  logic         In_Valid = 1'b0, Out_Ready = 1'b0;
  logic         In_Ready, Out_Valid, Out_Err;
  logic [127:0] InvMix_Out_T, InvMix_Out_F;

  int checks = 0, errors = 0;

  typedef struct {logic [127:0] t; logic [127:0] f; logic err;} exp_t;
  exp_t sb[$];

  localparam logic [127:0] FIPS_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] FIPS_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;

  inv_mix_columns_seq dut (
    .clk(clk), .rst_n(rst_n),
    .InvMix_In_T(InvMix_In_T), .InvMix_In_F(InvMix_In_F),
    .In_Valid(In_Valid), .In_Ready(In_Ready),
    .InvMix_Out_T(InvMix_Out_T), .InvMix_Out_F(InvMix_Out_F),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Err(Out_Err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] k);
    logic [7:0] acc, p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) acc = acc ^ p;
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  function automatic logic [127:0] invMixModel(input logic [127:0] s);
    logic [7:0]   a [4];
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-c*32-r*8 -: 8];
      for (int r = 0; r < 4; r++)
        o[127-c*32-r*8 -: 8] = gm(a[r], 8'h0e) ^ gm(a[(r+1)%4], 8'h0b) ^
                               gm(a[(r+2)%4], 8'h0d) ^ gm(a[(r+3)%4], 8'h09);
    end
    return o;
  endfunction

  // Runs one block from acceptance through handshake completion. The
  // task is entered 1 time unit after a rising edge with the DUT in
  // IDLE, and it returns at the same phase with the DUT back in IDLE.
  task automatic run_block(input logic [127:0] t, input logic [127:0] f,
                           input logic [127:0] refT, input logic expErr,
                           input int hold, input logic junk);
    exp_t e;
    checks++;
    if (In_Ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready got=%b want=1", In_Ready);
    end
    InvMix_In_T = t;
    InvMix_In_F = f;
    In_Valid    = 1'b1;
    e.t   = expErr ? '0 : refT;
    e.f   = expErr ? '0 : ~refT;
    e.err = expErr;
    sb.push_back(e);
    Out_Ready = (hold == 0);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      // The input is not held after acceptance. Junk may even be
      // offered as valid while the DUT is busy.
      In_Valid    = junk;
      InvMix_In_T = {$urandom, $urandom, $urandom, $urandom};
      InvMix_In_F = {$urandom, $urandom, $urandom, $urandom};
      checks++;
      if (Out_Valid !== 1'b0 || In_Ready !== 1'b0 || Out_Err !== 1'b0 ||
          InvMix_Out_T !== '0 || InvMix_Out_F !== '0) begin
        errors++;
        $display("FAIL busy_cycle%0d got valid=%b ready=%b err=%b T=%h F=%h want 0 0 0 0 0",
                 i, Out_Valid, In_Ready, Out_Err, InvMix_Out_T, InvMix_Out_F);
      end
      if (i % 2 == 0) begin
        checks++;
        if (dut.mixInT !== '0 || dut.mixInF !== '0) begin
          errors++;
          $display("FAIL pre_spacer%0d got T=%h F=%h want 0 0", i, dut.mixInT, dut.mixInF);
        end
      end
      @(posedge clk); #1;
    end
    In_Valid = 1'b0;
    checks++;
    if (Out_Valid !== 1'b1) begin
      errors++;
      $display("FAIL latency got valid=%b want=1 at 8 cycles", Out_Valid);
    end
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty");
    end else begin
      e = sb.pop_front();
      checks++;
      if (InvMix_Out_T !== e.t || InvMix_Out_F !== e.f || Out_Err !== e.err) begin
        errors++;
        $display("FAIL result got T=%h F=%h err=%b want T=%h F=%h err=%b",
                 InvMix_Out_T, InvMix_Out_F, Out_Err, e.t, e.f, e.err);
      end
      repeat (hold) begin
        @(posedge clk); #1;
        checks++;
        if (Out_Valid !== 1'b1 || In_Ready !== 1'b0 || InvMix_Out_T !== e.t ||
            InvMix_Out_F !== e.f || Out_Err !== e.err) begin
          errors++;
          $display("FAIL hold got valid=%b ready=%b T=%h err=%b want 1 0 T=%h err=%b",
                   Out_Valid, In_Ready, InvMix_Out_T, Out_Err, e.t, e.err);
        end
      end
    end
    Out_Ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (Out_Valid !== 1'b0 || In_Ready !== 1'b1 || Out_Err !== 1'b0 ||
        InvMix_Out_T !== '0 || InvMix_Out_F !== '0) begin
      errors++;
      $display("FAIL release got valid=%b ready=%b err=%b T=%h want 0 1 0 0",
               Out_Valid, In_Ready, Out_Err, InvMix_Out_T);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (In_Ready !== 1'b1 || Out_Valid !== 1'b0 || Out_Err !== 1'b0 ||
        InvMix_Out_T !== '0 || InvMix_Out_F !== '0) begin
      errors++;
      $display("FAIL reset got ready=%b valid=%b err=%b T=%h F=%h want 1 0 0 0 0",
               In_Ready, Out_Valid, Out_Err, InvMix_Out_T, InvMix_Out_F);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (In_Ready !== 1'b1 || Out_Valid !== 1'b0) begin
      errors++;
      $display("FAIL idle got ready=%b valid=%b want 1 0", In_Ready, Out_Valid);
    end
  endtask

  task automatic test_fips();
    logic [127:0] m;
    m = invMixModel(FIPS_IN);
    checks++;
    if (m !== FIPS_OUT) begin
      errors++;
      $display("FAIL model_fips got=%h want=%h", m, FIPS_OUT);
    end
    run_block(FIPS_IN, ~FIPS_IN, FIPS_OUT, 1'b0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_block(FIPS_IN, ~FIPS_IN, FIPS_OUT, 1'b0, 5, 1'b0);
    run_block({16{8'hc6}}, ~{16{8'hc6}}, {16{8'hc6}}, 1'b0, 0, 1'b0);
  endtask

  task automatic test_rail_err();
    logic [127:0] t, f;
    t = FIPS_IN;  t[0] = 1'b1;
    f = ~FIPS_IN; f[0] = 1'b1;
    run_block(t, f, FIPS_OUT, 1'b1, 2, 1'b0);
    run_block(FIPS_IN, ~FIPS_IN, FIPS_OUT, 1'b0, 0, 1'b0);
    // An all-spacer input is also a non-codeword.
    run_block('0, '0, '0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [127:0] t;
    for (int n = 0; n < 4; n++) begin
      t = {$urandom, $urandom, $urandom, $urandom};
      run_block(t, ~t, invMixModel(t), 1'b0, n % 2, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    InvMix_In_T = FIPS_IN;
    InvMix_In_F = ~FIPS_IN;
    In_Valid    = 1'b1;
    Out_Ready   = 1'b1;
    @(posedge clk); #1;
    In_Valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (In_Ready !== 1'b1 || Out_Valid !== 1'b0 || InvMix_Out_T !== '0) begin
      errors++;
      $display("FAIL mid_reset got ready=%b valid=%b T=%h want 1 0 0",
               In_Ready, Out_Valid, InvMix_Out_T);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      checks++;
      if (Out_Valid !== 1'b0) begin
        errors++;
        $display("FAIL aborted_block cycle%0d got valid=%b want=0", i, Out_Valid);
      end
    end
    run_block(FIPS_IN, ~FIPS_IN, FIPS_OUT, 1'b0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fips();
    test_backpressure();
    test_rail_err();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
